gf163_lsd_mult: RTL
===================

// Module: gf163_lsd_mult
// PURPOSE
//  Sequential digit-serial multiplier over GF(2^163) with reduction polynomial
//  f(x)=x^163+x^7+x^6+x^3+1. It scans b least-significant digit first, which is the
//  reverse scan direction of the MSB-first cell array. Used by point-arithmetic
//  sequencers as a start/done multiply engine. It computes c = a*b mod f in ceil(M/D) cycles.
// PARAMETERS
//  M     163   field degree (fixed for f above)
//  D     8     digit width, bits of b consumed per cycle; 1 <= D <= M-7
//  N     21    digit count = ceil(M/D); derived, never overridden
// PORTS
//  clk_in    in   1  clock, all logic on rising edge
//  rst_in    in   1  synchronous reset, active-high
//  start_in  in   1  request; sampled only when busy_out=0
//  a_in      in   M  operand a, captured with start
//  b_in      in   M  operand b, captured with start
//  sq_in     in   1  squaring request (only present with GF163_MULT_SQR_EN)
//  busy_out  out  1  high while digits are being processed
//  done_out  out  1  one-cycle pulse: c_out newly valid
//  c_out     out  M  product, held stable from done_out until the next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE. busy_out=0, done_out=0, c_out=0, digit counter=0, internal regs=0.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE or DONE with start_in=1: load A<=a_in, B<=b_in, C<=0, cnt<=0, go to RUN.
//    - RUN: on each edge, C <= C ^ (A * B[D*cnt +: D]) mod f and A <= A*x^D mod f.
//      - cnt increments. After cnt==N-1, go to DONE and register c_out <= next C.
//    - DONE lasts one cycle with done_out=1, then goes to IDLE unless start_in=1.
//  - Latency: start sampled at edge k; done_out=1 in the cycle after edge k+N.
//    - With D=8 that is edge k+21.
//  - busy_out=1 exactly in RUN. start_in is ignored during RUN; there is no queueing.
//  - Width: the last digit covers bits D*(N-1)..D*N-1, and bits >= M are zero-padded.
//    - With D=8, bits 163..167 of digit 20 are zero.
//  - Reduction:
//    - A*digit is at most M+D-1 bits wide.
//    - Fold the top D-1 bits once using x^163 = x^7+x^6+x^3+1. One fold suffices since D <= M-7.
//    - A*x^D is reduced the same way, purely combinationally within the cycle.
//  - Inputs with bits >= M cannot occur (port width M).
//  - rst_in in any state aborts the operation immediately.
//    - Next cycle: state IDLE, c_out=0, no done_out pulse.
//  - rst_in and start_in together: reset wins.
//  - c_out changes only at the DONE-entry edge or at reset.
// CONFIGURATION
//  - Macro GF163_MULT_SQR_EN.
//    - Defined: port sq_in exists. If sq_in=1 with an accepted start, b_in is ignored,
//      B<=a_in, and the result is a^2 mod f with identical latency.
//    - Undefined: no sq_in port and B<=b_in always. Timing and behaviour are otherwise identical.
// STRUCTURE
//  - Package gf163_pkg holds:
//    - localparams M, D, N and POLY_LOW = 8'b1100_1001 (x^7+x^6+x^3+1);
//    - state enum typedef {IDLE, RUN, DONE};
//    - function reduce_fold(M+D-1 bits) -> M bits.
//  - One combinational sub-module, gf163_digit_mac, with inputs A, C and digit.
//    - Outputs: C' = C ^ A*digit mod f and A' = A*x^D mod f.
//  - Top holds the FSM, counter, A/B/C registers and the c_out register.
// TESTING
//  1. a=1, b=1, start at edge 0 -> busy 1 for 21 cycles, done_out pulse after edge 21, c_out=1.
//  2. a=x^162, b=x -> c_out=163'h...00C9 (x^7+x^6+x^3+1), exercising the fold path.
//  3. a=random, b=0 -> c_out=0. Swap a/b with random values -> results equal (commutativity vs. model).
//  4. start_in pulsed at RUN cycles 3 and 15 -> ignored; single done, result of first operands.
//  5. rst_in at RUN cycle 10 -> next cycle busy=0, done=0, c_out=0.
//     - A new start afterwards gives a correct result.
//  6. GF163_MULT_SQR_EN defined: a=x^81, sq_in=1, b_in=all-ones -> c_out=x^162 (bit 162 only).
//     - start_in held high in DONE -> new op accepted with no idle gap.

Source files
------------

// File: rtl/gf163_pkg.sv
// Shared constants, FSM state type and the single-fold reduction helper for the GF(2^163)
// digit-serial multiplier.
package gf163_pkg;

  localparam int unsigned M  = 163;
  localparam int unsigned D  = 8;
  localparam int unsigned N  = (M + D - 1) / D;
  localparam int unsigned CW = $clog2(N);

  // x^7 + x^6 + x^3 + 1, i.e. x^163 mod f
  localparam logic [7:0] POLY_LOW = 8'b1100_1001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // One fold of the D-1 bits above x^(M-1); the folded terms stay below x^M because D <= M-7.
  function automatic logic [M-1:0] reduce_fold(input logic [M+D-2:0] v);
    logic [M-1:0] r;
    r = v[M-1:0];
    for (int i = 0; i < int'(D) - 1; i++) begin
      if (v[M+i]) r = r ^ (M'(POLY_LOW) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf163_digit_mac.sv
// Combinational digit step: C' = C ^ A*digit mod f and A' = A*x^D mod f.
module gf163_digit_mac
  import gf163_pkg::*;
(
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_c,
  input  logic [D-1:0] i_digit,
  output logic [M-1:0] o_c,
  output logic [M-1:0] o_a
);

  logic [M+D-2:0] w_prod;
  logic [M-1:0]   w_top_fold;

  always_comb begin
    w_prod = '0;
    for (int j = 0; j < int'(D); j++) begin
      if (i_digit[j]) w_prod = w_prod ^ ((M+D-1)'(i_a) << j);
    end
  end

  // The MSB of A lands on x^(M+D-1) = x^(D-1) * x^M, folded directly as a shifted constant.
  assign w_top_fold = i_a[M-1] ? (M'(POLY_LOW) << (D - 1)) : '0;

  assign o_c = i_c ^ reduce_fold(w_prod);
  assign o_a = reduce_fold({i_a[M-2:0], {D{1'b0}}}) ^ w_top_fold;

endmodule

// File: rtl/gf163_lsd_mult.sv
// LSD-first digit-serial GF(2^163) multiplier with start/done handshake.
// Optional squaring request port sq_in is enabled by defining GF163_MULT_SQR_EN.
module gf163_lsd_mult
  import gf163_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [M-1:0] a_in,
  input  logic [M-1:0] b_in,
`ifdef GF163_MULT_SQR_EN
  input  logic         sq_in,
`endif
  output logic         busy_out,
  output logic         done_out,
  output logic [M-1:0] c_out
);

  state_e              r_state;
  state_e              w_state_d;
  logic [CW-1:0]       r_cnt;
  logic [M-1:0]        r_a;
  logic [M-1:0]        r_b;
  logic [M-1:0]        r_c;
  logic [M-1:0]        r_c_out;
  logic [N-1:0][D-1:0] w_b_digits;
  logic [D-1:0]        w_digit;
  logic [M-1:0]        w_c_next;
  logic [M-1:0]        w_a_next;
  logic [M-1:0]        w_b_load;
  logic                w_accept;
  logic                w_last;

  // B is zero-padded above bit M-1 so the top digit reads zeros there.
  assign w_b_digits = (N*D)'(r_b);
  assign w_digit    = w_b_digits[r_cnt];
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_accept   = start_in && (r_state != RUN);

`ifdef GF163_MULT_SQR_EN
  assign w_b_load = sq_in ? a_in : b_in;
`else
  assign w_b_load = b_in;
`endif

  gf163_digit_mac u_mac (
    .i_a     (r_a),
    .i_c     (r_c),
    .i_digit (w_digit),
    .o_c     (w_c_next),
    .o_a     (w_a_next)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_d = RUN;
      RUN:     if (w_last) w_state_d = DONE;
      DONE:    w_state_d = start_in ? RUN : IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_c_out <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_a   <= a_in;
        r_b   <= w_b_load;
        r_c   <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a   <= w_a_next;
        r_c   <= w_c_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_c_out <= w_c_next;
      end
    end
  end

  assign busy_out = (r_state == RUN);
  assign done_out = (r_state == DONE);
  assign c_out    = r_c_out;

endmodule
